// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants and the EX/MEM payload type
package rv32_pkg;

    localparam int XLEN_P  = 32;
    localparam int PC_STEP = 4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_sel_e;

    typedef struct packed {
        logic [XLEN_P-1:0] pc;
        logic [XLEN_P-1:0] result;
        logic [XLEN_P-1:0] store_data;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX/MEM boundary bundle; EX_MISALIGN_TRAP_EN adds mem_misalign
interface ex_mem_stage_if #(parameter int XLEN = 32);

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [2:0]      ex_funct3;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] alu_result;
    logic            alu_z;
    logic            alu_n;
    logic            ex_flush;
    logic            mem_stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_valid;
    logic [XLEN-1:0] mem_pc;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_store_data;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            mem_mem_read;
    logic            mem_mem_write;
`ifdef EX_MISALIGN_TRAP_EN
    logic            mem_misalign;
`endif

    modport master (
        output ex_valid, ex_pc, ex_imm, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               alu_result, alu_z, alu_n, ex_flush, mem_stall,
        input  ex_ready, redirect_valid, redirect_pc, mem_valid, mem_pc, mem_alu_result,
               mem_store_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write
`ifdef EX_MISALIGN_TRAP_EN
        , input mem_misalign
`endif
    );

    modport slave (
        input  ex_valid, ex_pc, ex_imm, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               alu_result, alu_z, alu_n, ex_flush, mem_stall,
        output ex_ready, redirect_valid, redirect_pc, mem_valid, mem_pc, mem_alu_result,
               mem_store_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write
`ifdef EX_MISALIGN_TRAP_EN
        , output mem_misalign
`endif
    );

endinterface

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - maps funct3 and the ALU SUB flags to a branch-taken decision
module branch_cond
    import rv32_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    // N already reflects signed or unsigned compare, chosen upstream from funct3[1]
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:           taken = z;
            F3_BNE:           taken = ~z;
            F3_BLT, F3_BLTU:  taken = n;
            F3_BGE, F3_BGEU:  taken = ~n;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - branch resolution, redirect and EX/MEM register; EX_MISALIGN_TRAP_EN traps bad targets
module ex_mem_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    ex_mem_stage_if.slave  bus
);

    logic            taken;
    logic            fire;
    logic            is_cf;
    logic            misalign;
    logic            is_jump;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] wb_value;

    ex_mem_payload_t mem_q;
    logic            mem_valid_q;

    branch_cond u_branch_cond (
        .funct3 (bus.ex_funct3),
        .z      (bus.alu_z),
        .n      (bus.alu_n),
        .taken  (taken)
    );

    assign fire      = bus.ex_valid & ~bus.mem_stall & ~bus.ex_flush;
    assign is_jump   = bus.ex_is_jal | bus.ex_is_jalr;
    assign is_cf     = is_jump | (bus.ex_is_branch & taken);
    assign br_target = bus.ex_pc + bus.ex_imm;
    assign target    = bus.ex_is_jalr ? (bus.alu_result & {{(XLEN-1){1'b1}}, 1'b0}) : br_target;
    assign link      = bus.ex_pc + XLEN'(PC_STEP);

`ifdef EX_MISALIGN_TRAP_EN
    logic mem_misalign_q;
    assign misalign         = is_cf & target[1];
    assign bus.mem_misalign = mem_misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // A faulting target rides down the pipe in place of the link value
    assign wb_value = misalign ? target : (is_jump ? link : bus.alu_result);

    assign bus.ex_ready       = ~bus.mem_stall;
    assign bus.redirect_valid = ~rst & fire & is_cf & ~misalign;
    assign bus.redirect_pc    = rst ? XLEN'(PC_RESET) : target;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            mem_q       <= '0;
`ifdef EX_MISALIGN_TRAP_EN
            mem_misalign_q <= 1'b0;
`endif
        end else if (!bus.mem_stall) begin
            if (bus.ex_flush || !bus.ex_valid) begin
                mem_valid_q     <= 1'b0;
                mem_q.reg_write <= 1'b0;
                mem_q.mem_read  <= 1'b0;
                mem_q.mem_write <= 1'b0;
`ifdef EX_MISALIGN_TRAP_EN
                mem_misalign_q  <= 1'b0;
`endif
            end else begin
                mem_valid_q      <= 1'b1;
                mem_q.pc         <= bus.ex_pc;
                mem_q.result     <= wb_value;
                mem_q.store_data <= bus.ex_store_data;
                mem_q.rd         <= bus.ex_rd;
                mem_q.reg_write  <= bus.ex_reg_write & ~bus.ex_is_branch & ~misalign;
                mem_q.mem_read   <= bus.ex_mem_read;
                mem_q.mem_write  <= bus.ex_mem_write;
`ifdef EX_MISALIGN_TRAP_EN
                mem_misalign_q   <= misalign;
`endif
            end
        end
    end

    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_pc         = mem_q.pc;
    assign bus.mem_alu_result = mem_q.result;
    assign bus.mem_store_data = mem_q.store_data;
    assign bus.mem_rd         = mem_q.rd;
    assign bus.mem_reg_write  = mem_q.reg_write;
    assign bus.mem_mem_read   = mem_q.mem_read;
    assign bus.mem_mem_write  = mem_q.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage, optional EX_MISALIGN_TRAP_EN
module tb_ex_mem_stage;

    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    ex_mem_stage_if #(.XLEN(32)) bus ();

    ex_mem_stage #(.XLEN(32), .PC_RESET(PC_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        stall;
        logic        flush;
        logic [1:0]  kind;     // 0 plain, 1 branch, 2 jal, 3 jalr
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        z;
        logic        n;
        logic        rw;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic        exp_mv;
        logic        exp_mrw;
        logic [31:0] exp_res;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic st, input logic fl, input logic [1:0] kind,
                          input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic z, input logic n, input logic rw);
        bus.ex_valid      = v;
        bus.mem_stall     = st;
        bus.ex_flush      = fl;
        bus.ex_is_branch  = (kind == 2'd1);
        bus.ex_is_jal     = (kind == 2'd2);
        bus.ex_is_jalr    = (kind == 2'd3);
        bus.ex_funct3     = f3;
        bus.ex_pc         = pc;
        bus.ex_imm        = imm;
        bus.alu_result    = alu;
        bus.alu_z         = z;
        bus.alu_n         = n;
        bus.ex_reg_write  = rw;
        bus.ex_rd         = 5'd7;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_store_data = 32'h0;
    endtask

    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // reference state of the MEM register
    logic        e_valid, e_rw, e_mr, e_mw, e_mis;
    logic [31:0] e_pc, e_res, e_sd;
    logic [4:0]  e_rd;

    initial begin
        logic [31:0] a, b, pc, imm, alu, tgt, res;
        logic [2:0]  f3;
        logic [1:0]  kind;
        logic        v, st, fl, tk, mis, fire, rv, rw;

        n_vec  = 0;
        n_fail = 0;

        tbl[0] = '{1,0,0,2'd1,3'b000,32'h100,32'h20,32'h0,1,0,1, 1,32'h120,1,0,32'h0};
        tbl[1] = '{1,0,0,2'd1,3'b110,32'h104,32'h40,32'h5,0,0,1, 0,32'h0,1,0,32'h5};
        tbl[2] = '{1,0,0,2'd1,3'b010,32'h108,32'h40,32'h0,1,1,1, 0,32'h0,1,0,32'h0};
        tbl[3] = '{1,0,0,2'd1,3'b001,32'h200,32'hFFFF_FFF8,32'h9,0,0,0, 1,32'h1F8,1,0,32'h9};
        tbl[4] = '{1,0,0,2'd1,3'b101,32'h204,32'h10,32'h1,0,1,1, 0,32'h0,1,0,32'h1};
        tbl[5] = '{1,0,0,2'd2,3'b000,32'h300,32'h40,32'h77,0,0,1, 1,32'h340,1,1,32'h304};
        tbl[6] = '{1,0,0,2'd0,3'b000,32'h310,32'h0,32'hDEAD_BEEF,0,0,1, 0,32'h0,1,1,32'hDEAD_BEEF};
        tbl[7] = '{0,0,0,2'd2,3'b000,32'h320,32'h40,32'h0,0,0,1, 0,32'h0,0,0,32'h0};
        tbl[8] = '{1,0,1,2'd2,3'b000,32'h330,32'h40,32'h0,0,0,1, 0,32'h0,0,0,32'h0};
        tbl[9] = '{1,0,0,2'd2,3'b000,32'hFFFF_FFFC,32'h8,32'h0,0,0,1, 1,32'h4,1,1,32'h0};

        // reset with a taken JAL presented and MEM stalled
        rst = 1'b1;
        set_in(1, 1, 0, 2'd2, 3'b000, 32'h40, 32'h10, 32'h0, 0, 0, 1);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        chk("rst_mem_pc", bus.mem_pc, 32'h0);
        chk("rst_mem_rw", {31'b0, bus.mem_reg_write}, 32'h0);
        chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, PC_RST);
        chk("rst_ex_ready", {31'b0, bus.ex_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].valid, tbl[i].stall, tbl[i].flush, tbl[i].kind, tbl[i].f3, tbl[i].pc,
                   tbl[i].imm, tbl[i].alu, tbl[i].z, tbl[i].n, tbl[i].rw);
            #1;
            chk($sformatf("tbl%0d_redirect_valid", i), {31'b0, bus.redirect_valid}, {31'b0, tbl[i].exp_rv});
            if (tbl[i].exp_rv)
                chk($sformatf("tbl%0d_redirect_pc", i), bus.redirect_pc, tbl[i].exp_rpc);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_mem_valid", i), {31'b0, bus.mem_valid}, {31'b0, tbl[i].exp_mv});
            chk($sformatf("tbl%0d_mem_reg_write", i), {31'b0, bus.mem_reg_write}, {31'b0, tbl[i].exp_mrw});
            if (tbl[i].exp_mv)
                chk($sformatf("tbl%0d_mem_alu_result", i), bus.mem_alu_result, tbl[i].exp_res);
            @(negedge clk);
        end

        // taken branch held behind a 3-cycle stall
        set_in(1, 0, 0, 2'd0, 3'b000, 32'h500, 32'h0, 32'h1111, 0, 0, 1);
        @(posedge clk); @(negedge clk);
        set_in(1, 1, 0, 2'd1, 3'b000, 32'h600, 32'h10, 32'h0, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
            chk("stall_ex_ready", {31'b0, bus.ex_ready}, 32'h0);
            @(posedge clk); #1;
            chk("stall_mem_pc_held", bus.mem_pc, 32'h500);
            chk("stall_mem_res_held", bus.mem_alu_result, 32'h1111);
            chk("stall_mem_valid_held", {31'b0, bus.mem_valid}, 32'h1);
            @(negedge clk);
        end
        bus.mem_stall = 1'b0;
        #1;
        chk("release_redirect_valid", {31'b0, bus.redirect_valid}, 32'h1);
        chk("release_redirect_pc", bus.redirect_pc, 32'h610);
        @(posedge clk); #1;
        chk("release_mem_pc", bus.mem_pc, 32'h600);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        #1;
        chk("release_single_pulse", {31'b0, bus.redirect_valid}, 32'h0);
        @(negedge clk);

        // JALR with an odd, word-misaligned target
        set_in(1, 0, 0, 2'd3, 3'b000, 32'h400, 32'h0, 32'h2003, 0, 0, 1);
        #1;
`ifdef EX_MISALIGN_TRAP_EN
        chk("jalr_mis_redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
        @(posedge clk); #1;
        chk("jalr_mis_flag", {31'b0, bus.mem_misalign}, 32'h1);
        chk("jalr_mis_reg_write", {31'b0, bus.mem_reg_write}, 32'h0);
        chk("jalr_mis_result", bus.mem_alu_result, 32'h2002);
        chk("jalr_mis_valid", {31'b0, bus.mem_valid}, 32'h1);
`else
        chk("jalr_redirect_valid", {31'b0, bus.redirect_valid}, 32'h1);
        chk("jalr_redirect_pc", bus.redirect_pc, 32'h2002);
        @(posedge clk); #1;
        chk("jalr_link", bus.mem_alu_result, 32'h404);
        chk("jalr_reg_write", {31'b0, bus.mem_reg_write}, 32'h1);
`endif
        @(negedge clk);

        // wrapping JAL followed by reset while a redirect is presented
        set_in(1, 0, 0, 2'd2, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, 0, 1);
        #1;
        chk("wrap_redirect_pc", bus.redirect_pc, 32'h4);
        @(posedge clk); #1;
        chk("wrap_link", bus.mem_alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
        chk("midrst_redirect_pc", bus.redirect_pc, PC_RST);
        chk("midrst_ex_ready", {31'b0, bus.ex_ready}, 32'h1);
        @(posedge clk); #1;
        chk("midrst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        chk("midrst_mem_pc", bus.mem_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic against the reference model
        e_valid = 1'b0; e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_mis = 1'b0;
        e_pc = 32'h0; e_res = 32'h0; e_sd = 32'h0; e_rd = 5'h0;
        for (int it = 0; it < 400; it++) begin
            v    = ($urandom_range(0, 9) != 0);
            st   = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            kind = 2'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc   = {$urandom} & 32'hFFFF_FFFC;
            imm  = ($urandom_range(0, 1) == 0) ? ({$urandom} & 32'hFFFF_FFFC) : $urandom;
            rw   = $urandom_range(0, 1);
            alu  = (kind == 2'd1) ? a - b : $urandom;
            set_in(v, st, fl, kind, f3, pc, imm, alu, a == b,
                   f3[1] ? (a < b) : ($signed(a) < $signed(b)), rw);
            bus.ex_rd         = 5'($urandom_range(0, 31));
            bus.ex_mem_read   = $urandom_range(0, 1);
            bus.ex_mem_write  = $urandom_range(0, 1);
            bus.ex_store_data = $urandom;

            case (kind)
                2'd1:    begin tk = model_taken(f3, a, b); tgt = pc + imm; end
                2'd2:    begin tk = 1'b1; tgt = pc + imm; end
                2'd3:    begin tk = 1'b1; tgt = {alu[31:1], 1'b0}; end
                default: begin tk = 1'b0; tgt = 32'h0; end
            endcase
`ifdef EX_MISALIGN_TRAP_EN
            mis = tk & tgt[1];
`else
            mis = 1'b0;
`endif
            fire = v & ~st & ~fl;
            rv   = fire & tk & ~mis;
            #1;
            chk("rnd_redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, rv});
            if (rv)
                chk("rnd_redirect_pc", bus.redirect_pc, tgt);
            chk("rnd_ex_ready", {31'b0, bus.ex_ready}, {31'b0, ~st});

            if (!st) begin
                if (fl || !v) begin
                    e_valid = 1'b0; e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_mis = 1'b0;
                end else begin
                    res = mis ? tgt : ((kind >= 2'd2) ? pc + 32'd4 : alu);
                    e_valid = 1'b1;
                    e_pc    = pc;
                    e_res   = res;
                    e_sd    = bus.ex_store_data;
                    e_rd    = bus.ex_rd;
                    e_rw    = rw & (kind != 2'd1) & ~mis;
                    e_mr    = bus.ex_mem_read;
                    e_mw    = bus.ex_mem_write;
                    e_mis   = mis;
                end
            end
            @(posedge clk); #1;
            chk("rnd_mem_valid", {31'b0, bus.mem_valid}, {31'b0, e_valid});
            chk("rnd_mem_enables", {29'b0, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write},
                {29'b0, e_rw, e_mr, e_mw});
`ifdef EX_MISALIGN_TRAP_EN
            chk("rnd_mem_misalign", {31'b0, bus.mem_misalign}, {31'b0, e_mis});
`endif
            if (e_valid) begin
                chk("rnd_mem_pc", bus.mem_pc, e_pc);
                chk("rnd_mem_alu_result", bus.mem_alu_result, e_res);
                chk("rnd_mem_store_data", bus.mem_store_data, e_sd);
                chk("rnd_mem_rd", {27'b0, bus.mem_rd}, {27'b0, e_rd});
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
